// File: rtl/algorithm_multi_vc.sv
// algorithm_multi_vc
//   Route computation and virtual-channel allocation for one router input.
//   - Decodes the target coordinates that come with a header beat.
//   - Picks an output port by dimension-ordered routing (XY or YX).
//   - Allocates a VC on that port and locks the whole packet to that channel.
//   - The channel stays busy until the downstream stage pulses vc_release.
//   The data path is combinational (in -> out[ch]); only the FSM state,
//   lock_ch, vc_busy and drop_count are registered.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_t*             : AXIS slave input (TID selects header beats)
//   out_t*            : AXIS master outputs, one per channel (port*VC_NUMBER+vc)
//   current_grant     : preferred VC = current_grant % VC_NUMBER
//   target_x/target_y : destination of the header currently on the input
//   vc_release        : one-cycle pulse per channel that frees it
//   vc_busy           : allocation state per channel
//   drop_count        : saturating count of orphan beats dropped in IDLE
module algorithm_multi_vc #(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
`ifdef TDEST_PRESENT
  parameter int DEST_WIDTH     = 4,
`endif
`ifdef TUSER_PRESENT
  parameter int USER_WIDTH     = 4,
`endif
  parameter int VC_NUMBER      = 2,
  parameter int CHANNEL_NUMBER = 5 * VC_NUMBER,
  parameter int MAX_ROUTERS_X  = 4,
  parameter int MAX_ROUTERS_Y  = 4,
  parameter int ROUTER_X       = 0,
  parameter int ROUTER_Y       = 0,
  parameter int ROUTING_MODE   = 0,
  parameter int VC_ALLOC_MODE  = 1,
  parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = '1,
  localparam int X_WIDTH  = $clog2(MAX_ROUTERS_X),
  localparam int Y_WIDTH  = $clog2(MAX_ROUTERS_Y),
  localparam int CH_WIDTH = $clog2(CHANNEL_NUMBER)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_tvalid,
  output logic                                     in_tready,
  input  logic [DATA_WIDTH-1:0]                    in_tdata,
  input  logic                                     in_tlast,
  input  logic [ID_WIDTH-1:0]                      in_tid,
`ifdef TDEST_PRESENT
  input  logic [DEST_WIDTH-1:0]                    in_tdest,
  output logic [CHANNEL_NUMBER-1:0][DEST_WIDTH-1:0] out_tdest,
`endif
`ifdef TUSER_PRESENT
  input  logic [USER_WIDTH-1:0]                    in_tuser,
  output logic [CHANNEL_NUMBER-1:0][USER_WIDTH-1:0] out_tuser,
`endif
  output logic [CHANNEL_NUMBER-1:0]                 out_tvalid,
  input  logic [CHANNEL_NUMBER-1:0]                 out_tready,
  output logic [CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0] out_tdata,
  output logic [CHANNEL_NUMBER-1:0]                 out_tlast,
  output logic [CHANNEL_NUMBER-1:0][ID_WIDTH-1:0]   out_tid,
  input  logic [CH_WIDTH-1:0]                      current_grant,
  input  logic [X_WIDTH-1:0]                       target_x,
  input  logic [Y_WIDTH-1:0]                       target_y,
  input  logic [CHANNEL_NUMBER-1:0]                 vc_release,
  output logic [CHANNEL_NUMBER-1:0]                 vc_busy,
  output logic [7:0]                               drop_count
);

  typedef enum logic {IDLE, FORWARD} state_t;

  state_t              state, state_n;
  logic [CH_WIDTH-1:0] lock_ch;
  logic [CH_WIDTH-1:0] sel_ch, fwd_ch;
  logic                sel_ok, fwd_en, alloc, drop;
  int                  port, pref;

  // Port numbering: 0 local, 1 north (y<), 2 east (x>), 3 south (y>), 4 west (x<)
  function automatic int route_port(input logic [X_WIDTH-1:0] tx,
                                    input logic [Y_WIDTH-1:0] ty);
    int x_port, y_port;
    x_port = 0;
    y_port = 0;
    if (int'(tx) > ROUTER_X)      x_port = 2;
    else if (int'(tx) < ROUTER_X) x_port = 4;
    if (int'(ty) < ROUTER_Y)      y_port = 1;
    else if (int'(ty) > ROUTER_Y) y_port = 3;
    if (ROUTING_MODE == 0) return (x_port != 0) ? x_port : y_port;
    else                   return (y_port != 0) ? y_port : x_port;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage: route + VC selection against the registered busy map
  always_comb begin
    port   = route_port(target_x, target_y);
    pref   = int'(current_grant) % VC_NUMBER;
    sel_ok = 1'b0;
    sel_ch = '0;
    if (!vc_busy[CH_WIDTH'(port * VC_NUMBER + pref)]) begin
      sel_ok = 1'b1;
      sel_ch = CH_WIDTH'(port * VC_NUMBER + pref);
    end else if (VC_ALLOC_MODE == 1) begin
      // Descending scan so the lowest free index is the one that sticks
      for (int v = VC_NUMBER - 1; v >= 0; v--) begin
        if (!vc_busy[CH_WIDTH'(port * VC_NUMBER + v)]) begin
          sel_ok = 1'b1;
          sel_ch = CH_WIDTH'(port * VC_NUMBER + v);
        end
      end
    end
  end

  // Stage: packet FSM and input handshake
  always_comb begin
    state_n   = state;
    fwd_en    = 1'b0;
    fwd_ch    = lock_ch;
    in_tready = 1'b0;
    alloc     = 1'b0;
    drop      = 1'b0;
    // Everything stays quiet while reset is held
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          if (in_tvalid) begin
            if (in_tid == ROUTING_HEADER) begin
              if (sel_ok) begin
                fwd_en    = 1'b1;
                fwd_ch    = sel_ch;
                in_tready = out_tready[sel_ch];
                alloc     = out_tready[sel_ch];
                if (out_tready[sel_ch] && !in_tlast) state_n = FORWARD;
              end
            end else begin
              in_tready = 1'b1;
              drop      = 1'b1;
            end
          end
        end
        FORWARD: begin
          fwd_en    = in_tvalid;
          in_tready = out_tready[lock_ch];
          if (in_tvalid && out_tready[lock_ch] && in_tlast) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Stage: output demux, unselected channels carry a zeroed payload
  always_comb begin
    out_tvalid = '0;
    out_tdata  = '0;
    out_tlast  = '0;
    out_tid    = '0;
`ifdef TDEST_PRESENT
    out_tdest  = '0;
`endif
`ifdef TUSER_PRESENT
    out_tuser  = '0;
`endif
    for (int c = 0; c < CHANNEL_NUMBER; c++) begin
      if (fwd_en && fwd_ch == CH_WIDTH'(c)) begin
        out_tvalid[c] = 1'b1;
        out_tdata[c]  = in_tdata;
        out_tlast[c]  = in_tlast;
        out_tid[c]    = in_tid;
`ifdef TDEST_PRESENT
        out_tdest[c]  = in_tdest;
`endif
`ifdef TUSER_PRESENT
        out_tuser[c]  = in_tuser;
`endif
      end
    end
  end

  // Stage: registered control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lock_ch    <= '0;
      vc_busy    <= '0;
      drop_count <= '0;
    end else begin
      state <= state_n;
      if (alloc) lock_ch <= sel_ch;
      // Release and allocation never hit the same channel: allocation needs it free
      vc_busy <= (vc_busy & ~vc_release) |
                 (alloc ? (CHANNEL_NUMBER'(1) << sel_ch) : '0);
      if (drop) drop_count <= sat_inc(drop_count);
    end
  end

endmodule

// File: doc/algorithm_multi_vc.md
# algorithm_multi_vc

Per-input route computation and virtual-channel allocation stage of the NoC router, successor to the fixed two-VC version. It decodes the target router from each packet header, picks an output port by dimension-ordered routing (XY or YX), allocates one of `VC_NUMBER` virtual channels on that port, and locks the whole packet to the allocated channel. A channel stays allocated until the downstream stage releases it. The block sits between the input buffer and the crossbar demux, with one instance per router input.

## Interface
- `DATA_WIDTH`, 32: AXIS TDATA width. `ID_WIDTH`, `DEST_WIDTH` and `USER_WIDTH` (default 4) are present under the same `TID_PRESENT`/`TDEST_PRESENT`/`TUSER_PRESENT` defines as `axis_if`; TID is mandatory for this block.
- `VC_NUMBER`, 2: virtual channels per output port, ≥1.
- `CHANNEL_NUMBER`, 5*`VC_NUMBER`: number of output channels. Channel index = port*`VC_NUMBER` + vc.
- `MAX_ROUTERS_X` / `MAX_ROUTERS_Y`, 4: mesh size. The `*_WIDTH` parameters are the `$clog2` of each.
- `ROUTER_X`, `ROUTER_Y`, 0: coordinates of this router.
- `ROUTING_MODE`, 0: 0 = XY (resolve X first), 1 = YX.
- `VC_ALLOC_MODE`, 1: 0 = static (use only the preferred VC), 1 = dynamic (fall back to the lowest-index free VC on the same port).
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset. Single clock domain.
- `in`, axis_if.s: packet input. A header beat has TID == `ROUTING_HEADER`.
- `out[CHANNEL_NUMBER]`, axis_if.m: one output per channel.
- `current_grant`, in, `$clog2(CHANNEL_NUMBER)`: preferred VC = `current_grant % VC_NUMBER`.
- `target_x` / `target_y`, in, X/Y width: destination of the header currently presented. These are valid only while a header is on `in`.
- `vc_release`, in, `CHANNEL_NUMBER`: 1-cycle pulse that frees the corresponding channel.
- `vc_busy`, out, `CHANNEL_NUMBER`: allocation state of each channel.
- `drop_count`, out, 8: saturating count of orphan (non-header) beats dropped in IDLE.

## Operation
- **Port select.** Ports are 0 local, 1 north (y<), 2 east (x>), 3 south (y>), 4 west (x<).
  - XY mode: if x differs, go east/west; else if y differs, go north/south; else local.
  - YX mode: same rule with y resolved first.
- **VC select.** The preferred VC is used if it is free.
  - Otherwise, in dynamic mode, use the lowest-index free VC on the selected port.
  - If no VC on the port is free, the header stalls with `in.TREADY`=0 and no output TVALID.
- **FSM states.** The FSM has two states, IDLE and FORWARD. Register `lock_ch` holds the allocated channel.
- **IDLE, header valid, channel available.**
  - Drive `out[ch]` with the input beat. All other outputs have TVALID=0 and zeroed payload.
  - `in.TREADY` = `out[ch].TREADY`.
  - On handshake: `lock_ch`←ch and `vc_busy[ch]`←1.
  - If the header also has TLAST, stay in IDLE. Otherwise go to FORWARD.
- **IDLE, non-header beat valid.** Drop the beat: `in.TREADY`=1, nothing forwarded, `drop_count`+1 (saturates at 255).
- **FORWARD.**
  - Every beat goes to `out[lock_ch]` regardless of `target_*`/`current_grant`, with `in.TREADY` = `out[lock_ch].TREADY`.
  - A TLAST handshake returns the FSM to IDLE. `vc_busy` is NOT cleared by TLAST.
  - A header-TID beat arriving in FORWARD is forwarded as ordinary data.
- **Release.**
  - `vc_release[i]`=1 clears `vc_busy[i]` next edge.
  - A release on a free channel is ignored.
  - Release and a new allocation of the same channel in the same cycle cannot both occur, because allocation needs the channel free. If release and allocation hit different channels in the same cycle, both take effect.
  - A released channel is allocatable one cycle after the pulse; the comparison uses the registered `vc_busy`.
- **Reset, including mid-packet.** FSM→IDLE, `lock_ch`=0, `vc_busy`=0, `drop_count`=0. All out TVALID=0 and `in.TREADY`=0 while `rst_n`=0. After reset the remaining tail beats of an interrupted packet are orphans and are dropped.

## Timing
- The data path is combinational, with zero cycles of latency in → out. Only the FSM state, `lock_ch`, `vc_busy` and `drop_count` are registered.
- Allocation commits on the header handshake edge.
- `vc_busy` and `drop_count` update on the edge after the event.
- Out TVALID never depends on out TREADY (AXIS rule). `in.TREADY` may depend on `in.TVALID`/TID.
- A stalled header holds output TVALID low, so the allocation is not visible to the demux until a VC is free.

## Test plan
- **XY routing, 3-beat packet.** `ROUTER`=(1,1), `VC_NUMBER`=2, header target (3,0), grant=1, ready=1 → header on channel 5 (east, vc1), beats 2–3 also on 5 even though `target_*` is changed to (0,0) mid-packet. FSM returns to IDLE, `vc_busy`=0x20.
- **YX mode.** Same header with `ROUTING_MODE`=1 → channel 3 (north, vc1).
- **VC fallback.** Channel 5 busy, new east header with grant=1, `VC_ALLOC_MODE`=1 → channel 4. Repeat with `VC_ALLOC_MODE`=0 → `in.TREADY`=0 and all out TVALID=0 until `vc_release[5]` pulses, then the header is accepted one cycle later.
- **Both VCs busy.** Channels 4 and 5 busy, east header → stall. Pulse `vc_release[4]` → allocation to 4. `vc_release[4]` together with a header allocating channel 2 in the same cycle → `vc_busy` shows 2 set and 4 clear.
- **Orphan beats.** Non-header beat in IDLE → TREADY=1, no out TVALID, `drop_count`=1. 300 orphan beats → 255.
- **Reset mid-packet.** Assert `rst_n`=0 on beat 2 of a 4-beat packet → `vc_busy`=0, outputs idle. Beats 3–4 after reset are dropped, `drop_count`=2. A following header routes normally.
